// File: rtl/lcd_wr_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780-style LCD write sequencer:
//   - lcdState_e      : sequencer state encoding
//   - LCD_T_*         : default timing values in clock cycles (50 MHz)
//   - LCD_INIT_SEQ    : power-on instruction bytes, entry 0 issued first
//   - LCD_OP_*        : clear/home opcodes that need the long execution wait
//   - isClearHome()   : decides whether a byte needs the long wait
//   - maxOf()         : constant helper for sizing the shared down-counter
// Optional feature macro used by the consumers of this package: LCD_INIT_EN
// ----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWR,
    INIT,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcdState_e;

  localparam int unsigned LCD_T_AS_CYC        = 3;
  localparam int unsigned LCD_T_EN_CYC        = 12;
  localparam int unsigned LCD_T_AH_CYC        = 2;
  localparam int unsigned LCD_T_EXEC_CYC      = 2000;
  localparam int unsigned LCD_T_CLR_CYC       = 82000;
  localparam int unsigned LCD_T_PWR_CYC       = 750000;
  localparam int unsigned LCD_T_INIT_WAIT_CYC = 205000;

  localparam int unsigned LCD_INIT_LEN = 7;
  localparam logic [6:0][7:0] LCD_INIT_SEQ = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38, 8'h38
  };

  localparam logic [7:0] LCD_OP_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_OP_HOME     = 8'h02;
  localparam logic [7:0] LCD_OP_HOME_ALT = 8'h03;

  // Clear display and return home are the only instructions whose
  // execution time is in the millisecond range.
  function automatic logic isClearHome(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_OP_CLEAR) || (data == LCD_OP_HOME) ||
                   (data == LCD_OP_HOME_ALT));
  endfunction

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_wr_ctrl_if.sv
// ----------------------------------------------------------------------------
// lcd_wr_ctrl_if
// Valid/ready request channel from the core's LCD I/O register path into the
// LCD write sequencer.
//   i_req_vld   : request valid (master -> slave)
//   i_req_rs    : 0 = instruction, 1 = data
//   i_req_data  : byte to write
//   o_req_rdy   : sequencer can accept a byte (slave -> master)
//   o_busy      : a write sequence or execution wait is in progress
// ----------------------------------------------------------------------------
interface lcd_wr_ctrl_if;

  logic       i_req_vld;
  logic       i_req_rs;
  logic [7:0] i_req_data;
  logic       o_req_rdy;
  logic       o_busy;

  modport master (
    output i_req_vld,
    output i_req_rs,
    output i_req_data,
    input  o_req_rdy,
    input  o_busy
  );

  modport slave (
    input  i_req_vld,
    input  i_req_rs,
    input  i_req_data,
    output o_req_rdy,
    output o_busy
  );

endinterface

// File: rtl/lcd_wr_ctrl_init_rom.sv
// ----------------------------------------------------------------------------
// lcd_init_rom
// Combinational lookup of the power-on instruction sequence. Only used when
// the design is built with LCD_INIT_EN.
//   i_idx  : sequence index, 0..6
//   o_byte : instruction byte at that index (0x00 beyond the table)
// ----------------------------------------------------------------------------
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] i_idx,
  output logic [7:0] o_byte
);

  // Out-of-range indices read as 0x00 so the lookup never selects
  // outside the packed table.
  always_comb begin
    o_byte = 8'h00;
    if (i_idx < 3'(LCD_INIT_LEN)) begin
      o_byte = LCD_INIT_SEQ[i_idx];
    end
  end

endmodule

// File: rtl/lcd_wr_ctrl.sv
// ----------------------------------------------------------------------------
// lcd_wr_ctrl
// Write sequencer for an HD44780-style character LCD. Accepts one byte per
// valid/ready handshake and plays it out as SETUP -> PULSE (EN high) -> HOLD
// -> WAIT (execution time) before accepting the next byte.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   req            : request channel (lcd_wr_ctrl_if.slave)
//   o_lcd_on       : LCD power/backlight enable, always on
//   o_lcd_en       : EN strobe
//   o_lcd_rs       : register select, held from SETUP until next transfer
//   o_lcd_rw       : read/write, tied to write
//   o_lcd_data     : DB[7:0], held from SETUP until next transfer
// Configuration macro: LCD_INIT_EN - adds a power-on wait followed by the
// automatic 7-byte initialisation sequence before the first request is taken.
// ----------------------------------------------------------------------------
module lcd_wr_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS_CYC        = LCD_T_AS_CYC,
  parameter int unsigned T_EN_CYC        = LCD_T_EN_CYC,
  parameter int unsigned T_AH_CYC        = LCD_T_AH_CYC,
  parameter int unsigned T_EXEC_CYC      = LCD_T_EXEC_CYC,
  parameter int unsigned T_CLR_CYC       = LCD_T_CLR_CYC,
  parameter int unsigned T_PWR_CYC       = LCD_T_PWR_CYC,
  parameter int unsigned T_INIT_WAIT_CYC = LCD_T_INIT_WAIT_CYC
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  lcd_wr_ctrl_if.slave req,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  localparam int unsigned T_MAX = maxOf(maxOf(maxOf(T_AS_CYC, T_EN_CYC),
                                              maxOf(T_AH_CYC, T_EXEC_CYC)),
                                        maxOf(maxOf(T_CLR_CYC, T_PWR_CYC),
                                              T_INIT_WAIT_CYC));
  localparam int CNT_W = $clog2(T_MAX + 1);

  // A zero-length phase cannot be expressed by the load-N-1 counter scheme.
  if (T_AS_CYC == 0 || T_EN_CYC == 0 || T_AH_CYC == 0 || T_EXEC_CYC == 0 ||
      T_CLR_CYC == 0 || T_PWR_CYC == 0 || T_INIT_WAIT_CYC == 0) begin : gBadTiming
    $error("lcd_wr_ctrl: every timing parameter must be at least 1 cycle");
  end

  lcdState_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] waitLoad_d;
  logic             rdy_q;
  logic             busy_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;

`ifdef LCD_INIT_EN
  logic       initActive_q;
  logic [2:0] initIdx_q;
  logic [7:0] romByte;

  lcd_init_rom uInitRom (
    .i_idx  (initIdx_q),
    .o_byte (romByte)
  );
`endif

  // Length of the execution wait for the byte currently on the bus. The very
  // first initialisation byte gets the extra-long 4.1 ms wait.
  always_comb begin
    waitLoad_d = CNT_W'(T_EXEC_CYC - 1);
    if (isClearHome(rs_q, data_q)) begin
      waitLoad_d = CNT_W'(T_CLR_CYC - 1);
    end
`ifdef LCD_INIT_EN
    if (initActive_q && (initIdx_q == 3'd0)) begin
      waitLoad_d = CNT_W'(T_INIT_WAIT_CYC - 1);
    end
`endif
  end

  // Sequencer. Every timed state loads cnt_q with its length minus one on
  // entry and leaves when the counter reads zero, so each state lasts exactly
  // its parameter in cycles. Ready is raised on the same edge that leaves
  // WAIT so the next handshake can land on the following edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
`ifdef LCD_INIT_EN
      state_q      <= PWR;
      cnt_q        <= CNT_W'(T_PWR_CYC - 1);
      initActive_q <= 1'b1;
      initIdx_q    <= 3'd0;
`else
      state_q      <= IDLE;
      cnt_q        <= '0;
`endif
      rdy_q        <= 1'b0;
      busy_q       <= 1'b0;
      en_q         <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (rdy_q && req.i_req_vld) begin
            state_q <= SETUP;
            cnt_q   <= CNT_W'(T_AS_CYC - 1);
            rs_q    <= req.i_req_rs;
            data_q  <= req.i_req_data;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`ifdef LCD_INIT_EN
        PWR: begin
          busy_q <= 1'b1;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= INIT;
          end
        end
        INIT: begin
          rs_q    <= 1'b0;
          data_q  <= romByte;
          state_q <= SETUP;
          cnt_q   <= CNT_W'(T_AS_CYC - 1);
        end
`endif
        SETUP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= PULSE;
            cnt_q   <= CNT_W'(T_EN_CYC - 1);
            en_q    <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= HOLD;
            cnt_q   <= CNT_W'(T_AH_CYC - 1);
            en_q    <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= WAIT;
            cnt_q   <= waitLoad_d;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
`ifdef LCD_INIT_EN
            if (initActive_q && (initIdx_q != 3'(LCD_INIT_LEN - 1))) begin
              initIdx_q <= initIdx_q + 3'd1;
              state_q   <= INIT;
            end else begin
              initActive_q <= 1'b0;
              state_q      <= IDLE;
              rdy_q        <= 1'b1;
              busy_q       <= 1'b0;
            end
`else
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs; the LCD is powered and strictly written, never read.
  assign req.o_req_rdy = rdy_q;
  assign req.o_busy    = busy_q;
  assign o_lcd_on      = 1'b1;
  assign o_lcd_en      = en_q;
  assign o_lcd_rs      = rs_q;
  assign o_lcd_rw      = 1'b0;
  assign o_lcd_data    = data_q;

endmodule

// File: tb/tb_lcd_wr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_lcd_wr_ctrl
// Directed self-checking bench for lcd_wr_ctrl in the default build
// (LCD_INIT_EN undefined) with shortened timing:
// T_AS=2, T_EN=3, T_AH=1, T_EXEC=10, T_CLR=40, T_PWR=20.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lcd_wr_ctrl;

  localparam int AS   = 2;
  localparam int EN   = 3;
  localparam int AH   = 1;
  localparam int EXEC = 10;
  localparam int CLR  = 40;

  logic       clock;
  logic       rstN;
  logic       lcdOn;
  logic       lcdEn;
  logic       lcdRs;
  logic       lcdRw;
  logic [7:0] lcdData;

  int vectorCount = 0;
  int missCount   = 0;

  lcd_wr_ctrl_if reqIf ();

  lcd_wr_ctrl #(
    .T_AS_CYC   (AS),
    .T_EN_CYC   (EN),
    .T_AH_CYC   (AH),
    .T_EXEC_CYC (EXEC),
    .T_CLR_CYC  (CLR),
    .T_PWR_CYC  (20)
  ) dut (
    .i_clk      (clock),
    .i_rst_n    (rstN),
    .req        (reqIf.slave),
    .o_lcd_on   (lcdOn),
    .o_lcd_en   (lcdEn),
    .o_lcd_rs   (lcdRs),
    .o_lcd_rw   (lcdRw),
    .o_lcd_data (lcdData)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Backstop so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // One write: handshake on the next edge, then measure EN start, EN width,
  // bus stability and the cycle at which ready returns, relative to the
  // handshake edge (cycle 0 = just after it).
  task automatic applyStimulus(input string tag, input logic rs,
                               input logic [7:0] data, input int expWait);
    int   c;
    int   enFirst;
    int   enCount;
    int   rdyAt;
    logic busOk;
    checkOutput({tag, "_rdy_before"}, 32'(reqIf.o_req_rdy), 32'd1);
    reqIf.i_req_vld  = 1'b1;
    reqIf.i_req_rs   = rs;
    reqIf.i_req_data = data;
    nextCycle();
    reqIf.i_req_vld  = 1'b0;
    reqIf.i_req_rs   = ~rs;
    reqIf.i_req_data = ~data;
    c = 0; enFirst = -1; enCount = 0; rdyAt = -1; busOk = 1'b1;
    while (rdyAt < 0 && c < 300) begin
      if (lcdEn) begin
        if (enFirst < 0) enFirst = c;
        enCount++;
      end
      if (lcdData !== data || lcdRs !== rs) busOk = 1'b0;
      if (reqIf.o_req_rdy) begin
        rdyAt = c;
      end else begin
        nextCycle();
        c++;
      end
    end
    checkOutput({tag, "_en_start"}, 32'(enFirst), 32'(AS));
    checkOutput({tag, "_en_width"}, 32'(enCount), 32'(EN));
    checkOutput({tag, "_bus_stable"}, 32'(busOk), 32'd1);
    checkOutput({tag, "_rdy_cycle"}, 32'(rdyAt), 32'(AS + EN + AH + expWait));
    checkOutput({tag, "_busy_after"}, 32'(reqIf.o_busy), 32'd0);
  endtask

  // Valid held high for two bytes; the second byte is presented during the
  // first byte's whole sequence and must only be taken once ready returns.
  task automatic checkBackToBack();
    int         c;
    int         acc2;
    int         pulses;
    logic       prevEn;
    logic       accepting;
    logic       done;
    logic [7:0] seen [4];
    reqIf.i_req_vld  = 1'b1;
    reqIf.i_req_rs   = 1'b1;
    reqIf.i_req_data = 8'h48;
    nextCycle();
    reqIf.i_req_data = 8'h49;
    acc2 = -1; pulses = 0; prevEn = 1'b0; accepting = 1'b0; done = 1'b0;
    for (int k = 0; k < 4; k++) seen[k] = 8'h00;
    c = 0;
    while (!done && c < 200) begin
      if (lcdEn && !prevEn) begin
        if (pulses < 4) seen[pulses] = lcdData;
        pulses++;
      end
      prevEn = lcdEn;
      if (reqIf.o_req_rdy) begin
        if (reqIf.i_req_vld) accepting = 1'b1;
        else done = 1'b1;
      end
      if (!done) begin
        nextCycle();
        c++;
        if (accepting) begin
          acc2 = c;
          reqIf.i_req_vld = 1'b0;
          accepting = 1'b0;
        end
      end
    end
    checkOutput("b2b_finished", 32'(done), 32'd1);
    checkOutput("b2b_pulses", 32'(pulses), 32'd2);
    checkOutput("b2b_byte0", 32'(seen[0]), 32'h48);
    checkOutput("b2b_byte1", 32'(seen[1]), 32'h49);
    checkOutput("b2b_spacing", 32'(acc2), 32'(AS + EN + AH + EXEC + 1));
  endtask

  // Reset pulled while EN is high: EN must drop without waiting for a clock
  // edge, and the aborted byte must never be replayed.
  task automatic checkResetInPulse();
    int   c;
    logic sawEn;
    reqIf.i_req_vld  = 1'b1;
    reqIf.i_req_rs   = 1'b1;
    reqIf.i_req_data = 8'h55;
    nextCycle();
    reqIf.i_req_vld = 1'b0;
    c = 0;
    while (!lcdEn && c < 20) begin
      nextCycle();
      c++;
    end
    checkOutput("rst_reached_pulse", 32'(lcdEn), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_en_async", 32'(lcdEn), 32'd0);
    checkOutput("rst_data_cleared", 32'(lcdData), 32'h00);
    checkOutput("rst_rdy_low", 32'(reqIf.o_req_rdy), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rstN = 1'b1;
    nextCycle();
    checkOutput("rst_rdy_after", 32'(reqIf.o_req_rdy), 32'd1);
    sawEn = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (lcdEn) sawEn = 1'b1;
      nextCycle();
    end
    checkOutput("rst_no_retry", 32'(sawEn), 32'd0);
    checkOutput("rst_idle_busy", 32'(reqIf.o_busy), 32'd0);
  endtask

  initial begin
    rstN             = 1'b0;
    reqIf.i_req_vld  = 1'b0;
    reqIf.i_req_rs   = 1'b0;
    reqIf.i_req_data = 8'h00;

    // Reset values while i_rst_n is still low.
    #7;
    checkOutput("reset_rdy", 32'(reqIf.o_req_rdy), 32'd0);
    checkOutput("reset_busy", 32'(reqIf.o_busy), 32'd0);
    checkOutput("reset_en", 32'(lcdEn), 32'd0);
    checkOutput("reset_rw", 32'(lcdRw), 32'd0);
    checkOutput("reset_on", 32'(lcdOn), 32'd1);
    checkOutput("reset_data", 32'(lcdData), 32'h00);

    // Release at 10 ns; ready must be up after the very next edge.
    #3;
    rstN = 1'b1;
    nextCycle();
    checkOutput("release_rdy", 32'(reqIf.o_req_rdy), 32'd1);
    checkOutput("release_on", 32'(lcdOn), 32'd1);

    applyStimulus("data_41", 1'b1, 8'h41, EXEC);
    applyStimulus("clear_01", 1'b0, 8'h01, CLR);
    applyStimulus("ddram_80", 1'b0, 8'h80, EXEC);
    applyStimulus("home_03", 1'b0, 8'h03, CLR);
    applyStimulus("instr_04", 1'b0, 8'h04, EXEC);
    applyStimulus("data_01", 1'b1, 8'h01, EXEC);

    checkBackToBack();
    checkResetInPulse();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
